// File: rtl/dmem_fill_resp.sv
// Block-fill responder for dmem: assembles a cache line from MEM_W-wide backing-memory beats,
// turns snooped writes into dmem invalidations and refetches a line that is written while in flight.
module dmem_fill_resp #(
  parameter int LINE_W  = 256,
  parameter int MEM_W   = 64,
  parameter int BLK_LEN = 59
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLK_LEN-1:0] b_addr_d,
  input  logic               b_rd_d,
  output logic [LINE_W-1:0]  b_data_in_d,
  output logic               b_dv_d,
  output logic [BLK_LEN-1:0] inv_addr,
  output logic               inv,
  output logic [63:0]        m_addr,
  output logic               m_rd,
  input  logic [MEM_W-1:0]   m_data,
  input  logic               m_ack,
  input  logic [63:0]        s_addr,
  input  logic               s_wr
);

  localparam int BEATS  = LINE_W / MEM_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = $clog2(MEM_W / 8);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DV    = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]         state;
  logic [BLK_LEN-1:0] blk;
  logic [BEAT_W-1:0]  beat;
  logic               stale;
  logic               capture;
  logic               last_beat;
  logic               snoop_hit;
  logic [BLK_LEN-1:0] s_blk;
  logic               unused_s_addr;

  assign s_blk         = s_addr[63 -: BLK_LEN];
  assign unused_s_addr = ^s_addr[63-BLK_LEN:0];
  assign capture       = (state == FETCH) && m_ack;
  assign last_beat     = (beat == BEAT_W'(BEATS - 1));
  assign snoop_hit     = (state == FETCH) && s_wr && (s_blk == blk);

  assign m_rd   = (state == FETCH);
  assign m_addr = m_rd ? 64'({blk, beat, {OFF_W{1'b0}}}) : 64'd0;
  assign b_dv_d = (state == DV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      blk      <= '0;
      beat     <= '0;
      stale    <= 1'b0;
      inv      <= 1'b0;
      inv_addr <= '0;
    end else begin
      inv <= s_wr;
      if (s_wr) inv_addr <= s_blk;

      case (state)
        IDLE: begin
          if (b_rd_d) begin
            blk   <= b_addr_d;
            beat  <= '0;
            stale <= 1'b0;
            state <= FETCH;
          end
        end
        FETCH: begin
          // A hit on the final beat's edge folds straight into the refetch decision.
          if (capture && last_beat) begin
            if (stale || snoop_hit) begin
              stale <= 1'b0;
              beat  <= '0;
            end else begin
              state <= DV;
            end
          end else begin
            if (capture) beat <= beat + 1'b1;
            if (snoop_hit) stale <= 1'b1;
          end
        end
        DV:      state <= GAP;
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // One holding register per beat lane; beat 0 sits at the line LSBs.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
    logic [MEM_W-1:0] lane_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) lane_reg <= '0;
      else if (capture && beat == BEAT_W'(gi)) lane_reg <= m_data;
    end
    assign b_data_in_d[gi*MEM_W +: MEM_W] = lane_reg;
  end

endmodule

// File: tb/tb_dmem_fill_resp.sv
// Scoreboard bench for dmem_fill_resp: a versioned backing-memory model supplies beats, and
// snooped writes bump a block's version so every returned line must match current memory contents.
module tb_dmem_fill_resp;

  logic         clk;
  logic         rst;
  logic [58:0]  b_addr_d;
  logic         b_rd_d;
  logic [255:0] b_data_in_d;
  logic         b_dv_d;
  logic [58:0]  inv_addr;
  logic         inv;
  logic [63:0]  m_addr;
  logic         m_rd;
  logic [63:0]  m_data;
  logic         m_ack;
  logic [63:0]  s_addr;
  logic         s_wr;

  dmem_fill_resp dut (
    .clk(clk), .rst(rst), .b_addr_d(b_addr_d), .b_rd_d(b_rd_d),
    .b_data_in_d(b_data_in_d), .b_dv_d(b_dv_d), .inv_addr(inv_addr), .inv(inv),
    .m_addr(m_addr), .m_rd(m_rd), .m_data(m_data), .m_ack(m_ack),
    .s_addr(s_addr), .s_wr(s_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [58:0]  exp_fill_q[$];
  logic [58:0]  exp_inv_q[$];
  logic [63:0]  ack_addrs[$];
  int unsigned  ver[logic [58:0]];
  int           wait_cycles = 0;
  int           wcnt = 0;
  logic         pend = 1'b0;
  logic [63:0]  pend_addr = '0;
  logic         dv_prev = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [58:0] b;
    int unsigned v;
    b = a[63:5];
    v = ver.exists(b) ? ver[b] : 0;
    return {v, a[31:0]};
  endfunction

  function automatic logic [255:0] line_of(input logic [58:0] b);
    logic [255:0] l;
    for (int i = 0; i < 4; i++) l[i*64 +: 64] = mem_word({b, 2'(i), 3'b000});
    return l;
  endfunction

  // Snooped writes change backing memory: later reads of that block see a new version.
  always @(posedge clk) begin
    if (!rst && s_wr) begin
      if (ver.exists(s_addr[63:5])) ver[s_addr[63:5]] = ver[s_addr[63:5]] + 1;
      else ver[s_addr[63:5]] = 1;
    end
  end

  // Backing memory: acks a held m_rd after wait_cycles idle cycles.
  always @(negedge clk) begin
    if (rst || !m_rd) begin
      m_ack = 1'b0;
      wcnt  = 0;
      pend  = 1'b0;
    end else begin
      if (pend) chk("m_addr_stable", 256'(m_addr), 256'(pend_addr));
      if (wcnt >= wait_cycles) begin
        m_ack  = 1'b1;
        m_data = mem_word(m_addr);
        ack_addrs.push_back(m_addr);
        wcnt   = 0;
        pend   = 1'b0;
      end else begin
        m_ack     = 1'b0;
        wcnt++;
        pend      = 1'b1;
        pend_addr = m_addr;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a line or an invalidate.
  always @(negedge clk) begin
    if (rst) begin
      dv_prev = 1'b0;
    end else begin
      if (dv_prev) chk("gap_m_rd", 256'(m_rd), 256'(0));
      dv_prev = b_dv_d;
      if (b_dv_d) begin
        if (exp_fill_q.size() == 0) chk("dv_unexpected", 256'(1), 256'(0));
        else begin
          logic [58:0] b;
          b = exp_fill_q.pop_front();
          chk("fill_data", b_data_in_d, line_of(b));
          $display("fill blk=%0h data=%h", b, b_data_in_d);
        end
      end
      if (inv) begin
        if (exp_inv_q.size() == 0) chk("inv_unexpected", 256'(1), 256'(0));
        else begin
          logic [58:0] a;
          a = exp_inv_q.pop_front();
          chk("inv_addr", 256'(inv_addr), 256'(a));
          $display("inv addr=%0h", inv_addr);
        end
      end
    end
  end

  task automatic snoop(input logic [63:0] a);
    s_wr   = 1'b1;
    s_addr = a;
    exp_inv_q.push_back(a[63:5]);
    @(posedge clk);
    #1;
    s_wr = 1'b0;
    chk("inv_pulse", 256'(inv), 256'(1));
  endtask

  task automatic do_fill(input logic [58:0] blk, input int hold, input int exp_lat);
    int lat;
    lat = 0;
    ack_addrs.delete();
    b_addr_d = blk;
    b_rd_d   = 1'b1;
    exp_fill_q.push_back(blk);
    for (int i = 1; i <= 500; i++) begin
      @(posedge clk);
      if (i == 1) begin
        #1;
        b_addr_d = 59'({$urandom, $urandom});
      end
      @(negedge clk);
      if (b_dv_d) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) chk("dv_timeout", 256'(0), 256'(1));
    else if (exp_lat > 0) chk("latency", 256'(lat), 256'(exp_lat));
    if (hold != 0) begin
      @(posedge clk);
      #1;
    end
    b_rd_d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic stop;
    stop     = 1'b0;
    rst      = 1'b1;
    b_addr_d = '0;
    b_rd_d   = 1'b0;
    s_addr   = '0;
    s_wr     = 1'b0;
    m_ack    = 1'b0;
    m_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_rd", 256'(m_rd), 256'(0));
    chk("rst_outputs", {b_data_in_d}, 256'(0));
    chk("rst_inv", 256'({inv, inv_addr, b_dv_d, m_addr}), 256'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic fill of block 1, zero wait states.
    wait_cycles = 0;
    do_fill(59'h1, 0, 5);
    chk("basic_addrs", {ack_addrs[0], ack_addrs[1], ack_addrs[2], ack_addrs[3]},
        {64'h20, 64'h28, 64'h30, 64'h38});

    // Three wait states per beat.
    wait_cycles = 3;
    do_fill(59'h5, 0, 17);

    // Request held one cycle past b_dv_d: no second fill.
    wait_cycles = 0;
    do_fill(59'h3, 1, 5);
    repeat (4) begin
      @(negedge clk);
      chk("held_no_refill", 256'({m_rd, b_dv_d}), 256'(0));
    end

    // Snoop hits block 1 on the edge capturing beat 2: full refetch.
    fork
      do_fill(59'h1, 0, 9);
      begin
        repeat (3) @(posedge clk);
        #1;
        snoop(64'h28);
      end
    join
    chk("refetch_count", 256'(ack_addrs.size()), 256'(8));
    chk("refetch_addrs", {ack_addrs[3], ack_addrs[4], ack_addrs[5], ack_addrs[7]},
        {64'h38, 64'h20, 64'h28, 64'h38});

    // Snoop storm while idle.
    snoop(64'h0);
    snoop(64'h40);
    snoop(64'h80);
    snoop(64'hC0);
    @(posedge clk);
    #1;
    chk("storm_end", 256'(inv), 256'(0));
    chk("storm_drained", 256'(exp_inv_q.size()), 256'(0));

    // Reset after beat 1 is captured.
    b_addr_d = 59'h2;
    b_rd_d   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b1;
    b_rd_d = 1'b0;
    #1;
    chk("rst_mid_m_rd", 256'({m_rd, b_dv_d, inv}), 256'(0));
    chk("rst_mid_addr", 256'({m_addr, inv_addr}), 256'(0));
    chk("rst_mid_data", b_data_in_d, 256'(0));
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_dv", 256'(b_dv_d), 256'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_fill(59'h2, 0, 5);
    chk("post_rst_beat0", 256'(ack_addrs[0]), 256'(64'h40));

    // Random fills with concurrent random snoops.
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          wait_cycles = $urandom_range(0, 2);
          do_fill(59'($urandom_range(0, 3)), $urandom_range(0, 1), 0);
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk);
          #1;
          if (!stop && $urandom_range(0, 9) < 2) begin
            s_wr   = 1'b1;
            s_addr = 64'($urandom_range(0, 255));
            exp_inv_q.push_back(s_addr[63:5]);
          end else begin
            s_wr = 1'b0;
          end
        end
        s_wr = 1'b0;
      end
    join

    repeat (5) @(posedge clk);
    #1;
    chk("fills_drained", 256'(exp_fill_q.size()), 256'(0));
    chk("invs_drained", 256'(exp_inv_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
